julia_core: RTL and testbench

//  One Julia-set iteration engine; NUM_JULIA copies feed the framebuffer write controller (mem).

---
 rtl/julia_core.sv | 178 +++++++++++++++++
 tb/tb_julia_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : julia_core
// Description : Single Julia-set iteration engine. Accepts one pixel job,
//               iterates z <- z^2 + c in signed Q4.28 fixed point until the
//               orbit escapes |z|^2 > 4 or the iteration cap is reached, then
//               presents an ARGB pixel and its framebuffer byte address until
//               the write controller releases it via 'free'.
//               Optional macro JULIA_COLOR_EN selects the coloured palette;
//               without it the pixel is the raw iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
module julia_core #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned FRAC_BITS = 28,
  parameter int unsigned MAX_ITER  = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] px_x,
  input  logic [15:0] px_y,
  input  logic [31:0] z0_re,
  input  logic [31:0] z0_im,
  input  logic [31:0] c_re,
  input  logic [31:0] c_im,
  input  logic        free,
  output logic        busy,
  output logic        done,
  output logic [31:0] address,
  output logic [31:0] pixel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Escape radius squared (4.0) expressed in the Q8.56 scale of the products.
  localparam logic signed [64:0] c_escape_limit = 65'sd4 <<< (2 * FRAC_BITS);
  localparam logic [7:0]         c_max_iter     = 8'(MAX_ITER);
  localparam logic [31:0]        c_width        = 32'(WIDTH);

  state_t r_state;
  state_t w_state_next;

  logic signed [31:0] r_zr;
  logic signed [31:0] r_zi;
  logic signed [31:0] r_cr;
  logic signed [31:0] r_ci;
  logic signed [63:0] r_zr2;
  logic signed [63:0] r_zi2;
  logic signed [63:0] r_zrzi;
  logic [7:0]         r_iter;
  logic [31:0]        r_address;
  logic [31:0]        r_pixel;

  logic signed [64:0] w_mag;
  logic signed [64:0] w_diff;
  logic signed [64:0] w_diff_sh;
  logic signed [63:0] w_zrzi_sh;
  logic signed [31:0] w_zr_next;
  logic signed [31:0] w_zi_next;
  logic               w_escape;
  logic               w_cap;
  logic [31:0]        w_lin;
  logic [31:0]        w_addr;
  logic [31:0]        w_pixel;
  logic               w_unused_bits;

  // Squared magnitude and real-part difference carried at 65 bits so that the
  // sum of two non-negative 2^62-range products never overflows.
  assign w_mag     = {r_zr2[63], r_zr2} + {r_zi2[63], r_zi2};
  assign w_diff    = {r_zr2[63], r_zr2} - {r_zi2[63], r_zi2};
  assign w_diff_sh = w_diff >>> FRAC_BITS;
  // 2*zr*zi folded into the shift: one less fractional bit dropped.
  assign w_zrzi_sh = r_zrzi >>> (FRAC_BITS - 1);
  assign w_zr_next = w_diff_sh[31:0] + r_cr;
  assign w_zi_next = w_zrzi_sh[31:0] + r_ci;
  assign w_escape  = (w_mag > c_escape_limit);
  assign w_cap     = (r_iter == c_max_iter);

  // Upper bits are discarded on purpose: the new z wraps to 32 bits.
  assign w_unused_bits = ^{w_diff_sh[64:32], w_zrzi_sh[63:32]};

  assign w_lin  = {16'h0, px_y} * c_width + {16'h0, px_x};
  assign w_addr = BASE_ADDR + (w_lin << 2);

  // Colour word for the result latched when the orbit terminates.
  always_comb begin
    w_pixel = 32'h0;
`ifdef JULIA_COLOR_EN
    if (!w_escape) begin
      w_pixel = 32'hFF00_0000;
    end else begin
      w_pixel = {8'hFF, r_iter[5:0], 2'b00, r_iter[5:0], 2'b00, 8'hFF};
    end
`else
    w_pixel = {24'h0, r_iter};
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection; start only matters in IDLE, free only in HOLD.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = MUL;
      MUL:     w_state_next = CHECK;
      CHECK:   w_state_next = (w_escape || w_cap) ? HOLD : MUL;
      HOLD:    if (free) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Job capture, product pipeline, iteration update and result latching.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_zr      <= '0;
      r_zi      <= '0;
      r_cr      <= '0;
      r_ci      <= '0;
      r_zr2     <= '0;
      r_zi2     <= '0;
      r_zrzi    <= '0;
      r_iter    <= '0;
      r_address <= '0;
      r_pixel   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_zr      <= z0_re;
            r_zi      <= z0_im;
            r_cr      <= c_re;
            r_ci      <= c_im;
            r_iter    <= '0;
            r_address <= w_addr;
          end
        end
        MUL: begin
          r_zr2  <= r_zr * r_zr;
          r_zi2  <= r_zi * r_zi;
          r_zrzi <= r_zr * r_zi;
        end
        CHECK: begin
          if (w_escape || w_cap) begin
            r_pixel <= w_pixel;
          end else begin
            r_zr   <= w_zr_next;
            r_zi   <= w_zi_next;
            r_iter <= r_iter + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == HOLD);
  assign address = r_address;
  assign pixel   = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_julia_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_julia_core
// Description : Self-checking bench for julia_core. Directed cases for reset,
//               interior/escape corner values, address arithmetic and the
//               HOLD/release handshake, plus randomized jobs compared with a
//               plain-arithmetic orbit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_julia_core;

  localparam int FRAC = 28;
  localparam int MAXI = 64;
  localparam int WID  = 640;
  localparam longint LIMIT = longint'(4) << (2 * FRAC);

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] px_x = '0;
  logic [15:0] px_y = '0;
  logic [31:0] z0_re = '0;
  logic [31:0] z0_im = '0;
  logic [31:0] c_re = '0;
  logic [31:0] c_im = '0;
  logic        free = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] address;
  logic [31:0] pixel;

  int checks = 0;
  int errors = 0;

  julia_core #(
    .WIDTH(WID), .FRAC_BITS(FRAC), .MAX_ITER(MAXI), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .px_x(px_x), .px_y(px_y),
    .z0_re(z0_re), .z0_im(z0_im), .c_re(c_re), .c_im(c_im), .free(free),
    .busy(busy), .done(done), .address(address), .pixel(pixel)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] color(input int n, input bit interior);
    logic [7:0] k;
    k = {n[5:0], 2'b00};
`ifdef JULIA_COLOR_EN
    return interior ? 32'hFF00_0000 : {8'hFF, k, k, 8'hFF};
`else
    if (interior) return {24'h0, 8'(MAXI)};
    return {24'h0, n[7:0]};
`endif
  endfunction

  // Orbit of z under z^2 + c, done with 64-bit integers; 4.0 becomes 2^58.
  function automatic void model(input int zr0, input int zi0, input int cr, input int ci,
                                output int n, output logic [31:0] pix);
    longint zr, zi, a, b, p;
    zr = zr0;
    zi = zi0;
    n = -1;
    pix = '0;
    for (int it = 0; it <= MAXI; it++) begin
      a = zr * zr;
      b = zi * zi;
      p = zr * zi;
      if (a > LIMIT - b) begin
        n = it; pix = color(it, 1'b0); return;
      end
      if (it == MAXI) begin
        n = it; pix = color(it, 1'b1); return;
      end
      zr = longint'(int'(((a - b) >>> FRAC) + longint'(cr)));
      zi = longint'(int'((p >>> (FRAC - 1)) + longint'(ci)));
    end
  endfunction

  function automatic logic [31:0] addr_model(input int x, input int y);
    longint lin;
    lin = longint'(y) * WID + longint'(x);
    return 32'(lin * 4);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a job, wait for done, compare with the model, then release.
  task automatic run_job(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] zr, input logic [31:0] zi,
                         input logic [31:0] cr, input logic [31:0] ci,
                         input bit free_early, input int hold_cycles,
                         output int lat, output logic [31:0] pix_obs);
    int n;
    logic [31:0] exp_pix;
    logic [31:0] exp_addr;
    model(int'(zr), int'(zi), int'(cr), int'(ci), n, exp_pix);
    exp_addr = addr_model(int'(x), int'(y));
    px_x = x; px_y = y; z0_re = zr; z0_im = zi; c_re = cr; c_im = ci;
    start = 1'b1;
    free = free_early;
    tick();
    start = 1'b0;
    check({tag, "/busy_after_start"}, 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 600) begin
      tick();
      lat++;
    end
    pix_obs = pixel;
    check({tag, "/latency"}, lat, 2 * (n + 1));
    check({tag, "/pixel"}, pixel, exp_pix);
    check({tag, "/address"}, address, exp_addr);
    if (!free_early) begin
      for (int i = 0; i < hold_cycles; i++) begin
        tick();
        check({tag, "/hold_done"}, 32'(done), 32'd1);
        check({tag, "/hold_pixel"}, pixel, exp_pix);
      end
      free = 1'b1;
    end
    tick();
    check({tag, "/release_done"}, 32'(done), 32'd0);
    check({tag, "/release_busy"}, 32'(busy), 32'd0);
    free = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] pix;
    logic [31:0] exp_b_pix;
    logic [31:0] addr_hold;
    int nb;

    // Reset state.
    repeat (3) tick();
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/address", address, 32'd0);
    check("reset/pixel", pixel, 32'd0);
    n_rst = 1'b1;
    tick();

    // Asynchronous reset while in CHECK of a long job.
    px_x = 16'd5; px_y = 16'd7; z0_re = '0; z0_im = '0; c_re = '0; c_im = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_rst = 1'b0;
    #1;
    check("midreset/busy", 32'(busy), 32'd0);
    check("midreset/done", 32'(done), 32'd0);
    check("midreset/address", address, 32'd0);
    check("midreset/pixel", pixel, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Interior at origin: full iteration cap.
    run_job("origin", 16'd5, 16'd7, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2, lat, pix);
    check("origin/lat130", lat, 32'd130);
`ifdef JULIA_COLOR_EN
    check("origin/pix_const", pix, 32'hFF00_0000);
`else
    check("origin/pix_const", pix, 32'h0000_0040);
`endif

    // z0 = 2.0: |z|^2 = 4 exactly is not an escape; escapes at n=1.
    run_job("two", 16'd0, 16'd0, 32'h2000_0000, 32'h0, 32'h0, 32'h0, 1'b0, 1, lat, pix);
    check("two/lat4", lat, 32'd4);
`ifdef JULIA_COLOR_EN
    check("two/pix_const", pix, 32'hFF04_04FF);
`else
    check("two/pix_const", pix, 32'h0000_0001);
`endif

    // z0 = 3.0: escapes immediately; free already high during compute.
    run_job("three", 16'd1, 16'd0, 32'h3000_0000, 32'h0, 32'h0, 32'h0, 1'b1, 0, lat, pix);
    check("three/lat2", lat, 32'd2);
`ifdef JULIA_COLOR_EN
    check("three/pix_const", pix, 32'hFF00_00FF);
`else
    check("three/pix_const", pix, 32'h0000_0000);
`endif

    // Address arithmetic and a long stall in HOLD, then release with start high.
    px_x = 16'd3; px_y = 16'd2; z0_re = 32'h3000_0000; z0_im = '0; c_re = '0; c_im = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 600) begin
      tick();
      lat++;
    end
    check("stall/done", 32'(done), 32'd1);
    check("stall/address", address, 32'h0000_140C);
    addr_hold = address;
    pix = pixel;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall/done_stable", 32'(done), 32'd1);
      check("stall/addr_stable", address, addr_hold);
      check("stall/pix_stable", pixel, pix);
    end
    // Job B presented together with free while still in HOLD: must not be taken.
    px_x = 16'd100; px_y = 16'd9; z0_re = 32'h2000_0000; z0_im = '0;
    start = 1'b1;
    free = 1'b1;
    tick();
    check("release/done", 32'(done), 32'd0);
    check("release/busy", 32'(busy), 32'd0);
    // Still asserted in IDLE: now the job is accepted, free is ignored.
    tick();
    check("accept/busy", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    check("accept/busy_free_held", 32'(busy), 32'd1);
    free = 1'b0;
    model(32'h2000_0000, 0, 0, 0, nb, exp_b_pix);
    lat = 0;
    while (done !== 1'b1 && lat < 600) begin
      tick();
      lat++;
    end
    check("jobB/address", address, addr_model(100, 9));
    check("jobB/pixel", pixel, exp_b_pix);
    free = 1'b1;
    tick();
    free = 1'b0;
    check("jobB/release", 32'(busy), 32'd0);

    // Randomized jobs around the interesting |z| < 2 region, plus raw wraps.
    for (int j = 0; j < 16; j++) begin
      logic [31:0] rzr, rzi, rcr, rci;
      logic [15:0] rx, ry;
      rx  = 16'($urandom_range(639));
      ry  = 16'($urandom_range(479));
      rzr = 32'(int'($urandom % 32'h4000_0000) - 32'sh2000_0000);
      rzi = 32'(int'($urandom % 32'h4000_0000) - 32'sh2000_0000);
      rcr = 32'(int'($urandom % 32'h2000_0000) - 32'sh1000_0000);
      rci = 32'(int'($urandom % 32'h2000_0000) - 32'sh1000_0000);
      if (j % 5 == 4) begin
        rzr = $urandom; rzi = $urandom; rcr = $urandom; rci = $urandom;
        rx = 16'($urandom); ry = 16'($urandom);
      end
      run_job($sformatf("rand%0d", j), rx, ry, rzr, rzi, rcr, rci,
              1'($urandom % 2), int'($urandom_range(3)), lat, pix);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
